// File: rtl/wb_result_arbiter.sv
// Writeback arbiter: one small FIFO per execution unit, drained round-robin
// onto NUM_WB_PORTS writeback ports, with flush and sticky overflow detection.
module wb_result_arbiter #(
    parameter int NUM_UNITS    = 7,
    parameter int NUM_WB_PORTS = 2,
    parameter int DATA_W       = 32,
    parameter int ROB_ID_W     = 6,
    parameter int PREG_W       = 7,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush_i,
    input  logic [NUM_UNITS-1:0]                      unit_valid_i,
    input  logic [NUM_UNITS*DATA_W-1:0]               unit_result_i,
    input  logic [NUM_UNITS*ROB_ID_W-1:0]             unit_rob_id_i,
    input  logic [NUM_UNITS*PREG_W-1:0]               unit_phys_dest_i,
    input  logic [NUM_UNITS-1:0]                      unit_exception_i,
    output logic [NUM_UNITS-1:0]                      unit_ready_o,
    output logic [NUM_WB_PORTS-1:0]                   wb_valid_o,
    output logic [NUM_WB_PORTS*DATA_W-1:0]            wb_result_o,
    output logic [NUM_WB_PORTS*ROB_ID_W-1:0]          wb_rob_id_o,
    output logic [NUM_WB_PORTS*PREG_W-1:0]            wb_phys_dest_o,
    output logic [NUM_WB_PORTS-1:0]                   wb_exception_o,
    output logic [NUM_WB_PORTS*$clog2(NUM_UNITS)-1:0] wb_unit_id_o,
    output logic                                      overflow_o
);

    localparam int UID_W  = $clog2(NUM_UNITS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = DATA_W + ROB_ID_W + PREG_W + 1;
    localparam int GCNT_W = $clog2(NUM_WB_PORTS + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [UID_W:0]    UNITS_C     = (UID_W+1)'(NUM_UNITS);
    localparam logic [UID_W-1:0]  LAST_UNIT_C = UID_W'(NUM_UNITS - 1);
    localparam logic [GCNT_W-1:0] PORTS_C     = GCNT_W'(NUM_WB_PORTS);

    // Entry layout: {result, rob_id, phys_dest, exception}
    logic [ENT_W-1:0]  mem_r   [NUM_UNITS][FIFO_DEPTH];
    logic [PTR_W-1:0]  rptr_r  [NUM_UNITS];
    logic [PTR_W-1:0]  wptr_r  [NUM_UNITS];
    logic [CNT_W-1:0]  count_r [NUM_UNITS];
    logic [UID_W-1:0]  rr_ptr_r;
    logic              overflow_r;

    logic [ENT_W-1:0]  in_ent_s   [NUM_UNITS];
    logic [ENT_W-1:0]  head_s     [NUM_UNITS];
    logic [NUM_UNITS-1:0] ready_s;
    logic [NUM_UNITS-1:0] push_s;
    logic [NUM_UNITS-1:0] pop_s;
    logic [NUM_UNITS-1:0] grant_s;
    logic              drop_s;

    logic [NUM_WB_PORTS-1:0] port_vld_s;
    logic [UID_W-1:0]  port_unit_s [NUM_WB_PORTS];
    logic [ENT_W-1:0]  port_ent_s;
    logic [GCNT_W-1:0] ngrant_s;
    logic [UID_W:0]    scan_raw_s;
    logic [UID_W:0]    scan_s;
    logic [UID_W-1:0]  last_s;
    logic [UID_W-1:0]  rr_next_s;

    // Per-unit ready, incoming entry packing and FIFO head selection
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            ready_s[i]  = (count_r[i] < DEPTH_C);
            in_ent_s[i] = {unit_result_i[i*DATA_W +: DATA_W],
                           unit_rob_id_i[i*ROB_ID_W +: ROB_ID_W],
                           unit_phys_dest_i[i*PREG_W +: PREG_W],
                           unit_exception_i[i]};
            head_s[i]   = mem_r[i][rptr_r[i]];
        end
    end

    assign push_s = unit_valid_i & ready_s & {NUM_UNITS{~flush_i}};
    assign pop_s  = grant_s & {NUM_UNITS{~flush_i}};
    assign drop_s = (|(unit_valid_i & ~ready_s)) & ~flush_i;

    // Round-robin scan from rr_ptr, granting the first non-empty units to ports in order
    always_comb begin
        grant_s    = '0;
        port_vld_s = '0;
        ngrant_s   = '0;
        last_s     = rr_ptr_r;
        scan_raw_s = '0;
        scan_s     = '0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            port_unit_s[p] = '0;
        end
        for (int k = 0; k < NUM_UNITS; k++) begin
            scan_raw_s = {1'b0, rr_ptr_r} + (UID_W+1)'(k);
            scan_s     = (scan_raw_s >= UNITS_C) ? (scan_raw_s - UNITS_C) : scan_raw_s;
            if ((count_r[scan_s[UID_W-1:0]] != '0) && (ngrant_s < PORTS_C)) begin
                grant_s[scan_s[UID_W-1:0]] = 1'b1;
                port_vld_s[ngrant_s]       = 1'b1;
                port_unit_s[ngrant_s]      = scan_s[UID_W-1:0];
                last_s                     = scan_s[UID_W-1:0];
                ngrant_s                   = ngrant_s + GCNT_W'(1);
            end else begin
                ngrant_s = ngrant_s;
            end
        end
        rr_next_s = (last_s == LAST_UNIT_C) ? '0 : (last_s + UID_W'(1));
    end

    // Writeback ports driven from granted heads; flush blanks every port
    always_comb begin
        wb_valid_o     = '0;
        wb_result_o    = '0;
        wb_rob_id_o    = '0;
        wb_phys_dest_o = '0;
        wb_exception_o = '0;
        wb_unit_id_o   = '0;
        port_ent_s     = '0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            port_ent_s = head_s[port_unit_s[p]];
            if (port_vld_s[p] && !flush_i) begin
                wb_valid_o[p]                          = 1'b1;
                wb_result_o[p*DATA_W +: DATA_W]        = port_ent_s[ENT_W-1 -: DATA_W];
                wb_rob_id_o[p*ROB_ID_W +: ROB_ID_W]    = port_ent_s[PREG_W+1 +: ROB_ID_W];
                wb_phys_dest_o[p*PREG_W +: PREG_W]     = port_ent_s[1 +: PREG_W];
                wb_exception_o[p]                      = port_ent_s[0];
                wb_unit_id_o[p*UID_W +: UID_W]         = port_unit_s[p];
            end else begin
                wb_valid_o[p] = 1'b0;
            end
        end
    end

    // FIFO occupancy and pointers; flush empties every FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                count_r[i] <= '0;
                rptr_r[i]  <= '0;
                wptr_r[i]  <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                count_r[i] <= '0;
                rptr_r[i]  <= '0;
                wptr_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (push_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + PTR_W'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
                    2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    mem_r[i][d] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wptr_r[i]] <= in_ent_s[i];
                end
            end
        end
    end

    // Round-robin pointer: resumes after the last granted unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (flush_i) begin
            rr_ptr_r <= '0;
        end else if (|grant_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end

    // Sticky overflow, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign unit_ready_o = ready_s;
    assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter: a two-port and a one-port instance share
// the same stimulus; a vector table plus hand sequences check each behaviour.
module tb_wb_result_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [6:0]   uv;
    logic [223:0] ures;
    logic [41:0]  urob;
    logic [48:0]  upreg;
    logic [6:0]   uexc;

    logic [6:0]   rdy0;
    logic [1:0]   v0;
    logic [63:0]  res0;
    logic [11:0]  rob0;
    logic [13:0]  preg0;
    logic [1:0]   exc0;
    logic [5:0]   uid0;
    logic         ovf0;

    logic [6:0]   rdy1;
    logic [0:0]   v1;
    logic [31:0]  res1;
    logic [5:0]   rob1;
    logic [6:0]   preg1;
    logic [0:0]   exc1;
    logic [2:0]   uid1;
    logic         ovf1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_result_arbiter #(.NUM_WB_PORTS(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .unit_valid_i(uv), .unit_result_i(ures), .unit_rob_id_i(urob),
        .unit_phys_dest_i(upreg), .unit_exception_i(uexc),
        .unit_ready_o(rdy0), .wb_valid_o(v0), .wb_result_o(res0),
        .wb_rob_id_o(rob0), .wb_phys_dest_o(preg0), .wb_exception_o(exc0),
        .wb_unit_id_o(uid0), .overflow_o(ovf0)
    );

    wb_result_arbiter #(.NUM_WB_PORTS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .unit_valid_i(uv), .unit_result_i(ures), .unit_rob_id_i(urob),
        .unit_phys_dest_i(upreg), .unit_exception_i(uexc),
        .unit_ready_o(rdy1), .wb_valid_o(v1), .wb_result_o(res1),
        .wb_rob_id_o(rob1), .wb_phys_dest_o(preg1), .wb_exception_o(exc1),
        .wb_unit_id_o(uid1), .overflow_o(ovf1)
    );

    typedef struct {
        logic [6:0] valid;
        logic [1:0] exp_vld;
        int         u[2];
        int         s[2];
        logic [6:0] exp_rdy;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [31:0] f_res(input int u, input int s);
        return 32'hC000_0000 + (32'(u) << 16) + 32'(s);
    endfunction
    function automatic logic [5:0] f_rob(input int u, input int s);
        return 6'(u * 8 + s);
    endfunction
    function automatic logic [6:0] f_preg(input int u, input int s);
        return 7'(u * 16 + s);
    endfunction
    function automatic logic f_exc(input int u, input int s);
        return 1'(u + s);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_unit(input int u, input logic v, input logic [31:0] r,
                            input logic [5:0] rb, input logic [6:0] pg, input logic e);
        uv[u]              = v;
        ures[u*32 +: 32]   = r;
        urob[u*6 +: 6]     = rb;
        upreg[u*7 +: 7]    = pg;
        uexc[u]            = e;
    endtask

    task automatic drive_pat(input logic [6:0] vmask, input int s);
        for (int u = 0; u < 7; u++) begin
            set_unit(u, vmask[u], f_res(u, s), f_rob(u, s), f_preg(u, s), f_exc(u, s));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        drive_pat(7'd0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int u;
        int s;
        int got;
        logic [2:0] exp_uid;

        // Two-port vector table, each record is one cycle; push data uses seq = record index
        tbl[0]  = '{7'b0000111, 2'b00, '{0, 0}, '{0, 0},  7'h7F};
        tbl[1]  = '{7'b0000000, 2'b11, '{0, 1}, '{0, 0},  7'h7F};
        tbl[2]  = '{7'b0000000, 2'b01, '{2, 0}, '{0, 0},  7'h7F};
        tbl[3]  = '{7'b0010001, 2'b00, '{0, 0}, '{0, 0},  7'h7F};
        tbl[4]  = '{7'b0000000, 2'b11, '{4, 0}, '{3, 3},  7'h7F};
        tbl[5]  = '{7'b0100000, 2'b00, '{0, 0}, '{0, 0},  7'h7F};
        tbl[6]  = '{7'b0100000, 2'b01, '{5, 0}, '{5, 0},  7'h7F};
        tbl[7]  = '{7'b0000000, 2'b01, '{5, 0}, '{6, 0},  7'h7F};
        tbl[8]  = '{7'b1000011, 2'b00, '{0, 0}, '{0, 0},  7'h7F};
        tbl[9]  = '{7'b0000000, 2'b11, '{6, 0}, '{8, 8},  7'h7F};
        tbl[10] = '{7'b0000000, 2'b01, '{1, 0}, '{8, 0},  7'h7F};
        tbl[11] = '{7'b0011100, 2'b00, '{0, 0}, '{0, 0},  7'h7F};
        tbl[12] = '{7'b0011100, 2'b11, '{2, 3}, '{11, 11}, 7'h7F};
        tbl[13] = '{7'b0000000, 2'b11, '{4, 2}, '{11, 12}, 7'b1101111};
        tbl[14] = '{7'b0000000, 2'b11, '{3, 4}, '{12, 12}, 7'h7F};
        tbl[15] = '{7'b0000000, 2'b00, '{0, 0}, '{0, 0},  7'h7F};

        uv = '0; ures = '0; urob = '0; upreg = '0; uexc = '0;

        // Single result through reset state
        do_reset();
        @(negedge clk);
        set_unit(3, 1'b1, 32'hDEADBEEF, 6'd5, 7'd17, 1'b0);
        #1;
        check("rst_valid", 64'(v0), 64'd0);
        check("rst_result", res0, 64'd0);
        check("rst_uid", 64'(uid0), 64'd0);
        check("rst_ready", 64'(rdy0), 64'h7F);
        check("rst_overflow", 64'(ovf0), 64'd0);
        @(negedge clk);
        uv = '0;
        #1;
        check("t1_valid", 64'(v0), 64'b01);
        check("t1_result", 64'(res0[31:0]), 64'hDEADBEEF);
        check("t1_rob", 64'(rob0[5:0]), 64'd5);
        check("t1_preg", 64'(preg0[6:0]), 64'd17);
        check("t1_exc", 64'(exc0[0]), 64'd0);
        check("t1_uid", 64'(uid0[2:0]), 64'd3);
        @(negedge clk);
        #1;
        check("t1_after_valid", 64'(v0), 64'd0);

        // Table-driven sharing, rr progression, wrap and full-unit ready
        do_reset();
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            drive_pat(tbl[r].valid, r);
            #1;
            check($sformatf("tbl%0d_valid", r), 64'(v0), 64'(tbl[r].exp_vld));
            check($sformatf("tbl%0d_ready", r), 64'(rdy0), 64'(tbl[r].exp_rdy));
            for (int p = 0; p < 2; p++) begin
                u = tbl[r].u[p];
                s = tbl[r].s[p];
                if (tbl[r].exp_vld[p]) begin
                    check($sformatf("tbl%0d_p%0d_uid", r, p), 64'(uid0[p*3 +: 3]), 64'(u));
                    check($sformatf("tbl%0d_p%0d_res", r, p), 64'(res0[p*32 +: 32]), 64'(f_res(u, s)));
                    check($sformatf("tbl%0d_p%0d_rob", r, p), 64'(rob0[p*6 +: 6]), 64'(f_rob(u, s)));
                    check($sformatf("tbl%0d_p%0d_preg", r, p), 64'(preg0[p*7 +: 7]), 64'(f_preg(u, s)));
                    check($sformatf("tbl%0d_p%0d_exc", r, p), 64'(exc0[p]), 64'(f_exc(u, s)));
                end else begin
                    check($sformatf("tbl%0d_p%0d_idle_res", r, p), 64'(res0[p*32 +: 32]), 64'd0);
                    check($sformatf("tbl%0d_p%0d_idle_uid", r, p), 64'(uid0[p*3 +: 3]), 64'd0);
                end
            end
        end

        // Fairness on the one-port instance: units 0 and 6 push every cycle
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            drive_pat(7'b1000001, 20 + c);
            #1;
            if (c == 0) begin
                check("fair_first_valid", 64'(v1), 64'd0);
            end else begin
                exp_uid = (c % 2 == 1) ? 3'd0 : 3'd6;
                check($sformatf("fair%0d_valid", c), 64'(v1), 64'd1);
                check($sformatf("fair%0d_uid", c), 64'(uid1), 64'(exp_uid));
            end
        end

        // Full / overflow on the one-port instance: units 0-3 keep the port busy
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_pat({3'b000, rdy1[3:0]}, 30 + c);
            set_unit(4, 1'b1, 32'h4A00_0000 + 32'(c), 6'd40, 7'd44, 1'b1);
            #1;
            if (c < 2) begin
                check($sformatf("full_ready4_c%0d", c), 64'(rdy1[4]), 64'd1);
            end else begin
                check("full_ready4_c2", 64'(rdy1[4]), 64'd0);
                check("full_ovf_before", 64'(ovf1), 64'd0);
            end
        end
        got = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            uv = '0;
            #1;
            if (c == 0) begin
                check("full_ovf_after", 64'(ovf1), 64'd1);
            end
            if (v1[0] && (uid1 == 3'd4)) begin
                if (got < 2) begin
                    check($sformatf("full_drain%0d_res", got), 64'(res1), 64'(32'h4A00_0000 + 32'(got)));
                end
                got++;
            end
        end
        check("full_drain_count", 64'(got), 64'd2);
        check("full_ovf_sticky", 64'(ovf1), 64'd1);

        // Flush with buffered entries and a same-cycle push
        do_reset();
        @(negedge clk);
        drive_pat(7'b0100010, 50);
        #1;
        @(negedge clk);
        drive_pat(7'b0100010, 51);
        #1;
        check("flush_pre_valid", 64'(v0), 64'b11);
        @(negedge clk);
        drive_pat(7'b0000100, 52);
        flush = 1'b1;
        #1;
        check("flush_pre_full5", 64'(rdy1[5]), 64'd0);
        check("flush_cycle_valid0", 64'(v0), 64'd0);
        check("flush_cycle_valid1", 64'(v1), 64'd0);
        check("flush_cycle_res0", res0, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        uv = '0;
        #1;
        check("flush_after_valid", 64'({v0, v1}), 64'd0);
        check("flush_after_ready0", 64'(rdy0), 64'h7F);
        check("flush_after_ready1", 64'(rdy1), 64'h7F);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("flush_stale%0d", c), 64'({v0, v1}), 64'd0);
        end

        // Asynchronous reset between edges while FIFOs hold entries
        do_reset();
        @(negedge clk);
        drive_pat(7'h7F, 60);
        #1;
        @(negedge clk);
        uv = '0;
        #1;
        check("areset_pre_valid", 64'(v0), 64'b11);
        check("areset_pre_uid", 64'(uid0), 64'b001_000);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid0", 64'(v0), 64'd0);
        check("areset_valid1", 64'(v1), 64'd0);
        check("areset_res", res0, 64'd0);
        check("areset_rob", 64'(rob0), 64'd0);
        check("areset_preg", 64'(preg0), 64'd0);
        check("areset_exc", 64'(exc0), 64'd0);
        check("areset_uid", 64'(uid0), 64'd0);
        check("areset_ready", 64'(rdy0), 64'h7F);
        check("areset_ovf", 64'(ovf1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("areset_stale%0d", c), 64'({v0, v1}), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_result_arbiter.md
Name: wb_result_arbiter

Overview:
- Parametrised writeback arbiter between the execution units and the physical register file / ROB completion ports.
- Accepts completed results from NUM_UNITS execution units, one small FIFO per unit, and drains up to NUM_WB_PORTS results per cycle.
- Arbitration is round-robin; flush discards all buffered results.
- Replaces fixed one-port-per-unit writeback; adds backpressure (unit_ready), fair sharing of fewer writeback ports, and overflow detection.

Parameters:
- NUM_UNITS, 7, number of producing execution units (index 0..NUM_UNITS-1)
- NUM_WB_PORTS, 2, writeback ports per cycle (1..NUM_UNITS)
- DATA_W, 32, result width
- ROB_ID_W, 6, ROB tag width
- PREG_W, 7, physical destination register width
- FIFO_DEPTH, 2, entries per unit FIFO (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered results
- unit_valid_i  in  NUM_UNITS  per-unit result valid
- unit_result_i  in  NUM_UNITS*DATA_W  results, unit i at [i*DATA_W +: DATA_W]
- unit_rob_id_i  in  NUM_UNITS*ROB_ID_W  ROB tags, same packing
- unit_phys_dest_i  in  NUM_UNITS*PREG_W  destination pregs, same packing
- unit_exception_i  in  NUM_UNITS  exception flag per result
- unit_ready_o  out  NUM_UNITS  unit FIFO can accept a push this cycle
- wb_valid_o  out  NUM_WB_PORTS  writeback port valid
- wb_result_o  out  NUM_WB_PORTS*DATA_W  writeback data, port p at [p*DATA_W +: DATA_W]
- wb_rob_id_o  out  NUM_WB_PORTS*ROB_ID_W  writeback ROB tag
- wb_phys_dest_o  out  NUM_WB_PORTS*PREG_W  writeback preg
- wb_exception_o  out  NUM_WB_PORTS  writeback exception flag
- wb_unit_id_o  out  NUM_WB_PORTS*$clog2(NUM_UNITS)  source unit of each port
- overflow_o  out  1  sticky: push attempted while full

Behaviour:
- Reset (async, rst_n=0): all FIFO counts, read/write pointers and rr_ptr cleared to 0; overflow_o=0.
  - Consequence: unit_ready_o = all ones; wb_valid_o = 0; wb_result_o, wb_rob_id_o, wb_phys_dest_o, wb_exception_o, wb_unit_id_o = 0.
- Push: unit_valid_i[i]=1 and count[i]<FIFO_DEPTH writes {result, rob_id, phys_dest, exception} at the edge.
  - unit_ready_o[i] = (count[i] < FIFO_DEPTH), combinational from registered count.
  - It does not account for a same-cycle pop; this is conservative.
- Push while full: data dropped, FIFO unchanged, overflow_o set to 1. Cleared only by reset.
- Writeback outputs are combinational from FIFO heads.
  - Latency: a push at edge t is visible on a wb port in cycle t+1 at the earliest.
  - wb ports never stall; a granted head is popped at the end of that cycle.
- Arbitration:
  - Scan units in order rr_ptr, rr_ptr+1, ... mod NUM_UNITS.
  - The first NUM_WB_PORTS non-empty units are granted to ports 0,1,... in scan order.
  - Ungranted ports: valid=0, all payload fields 0.
  - At most one entry per unit per cycle.
- rr_ptr update: if any grant, rr_ptr <= (index of last granted unit + 1) mod NUM_UNITS; otherwise unchanged.
- Simultaneous push and pop on the same FIFO: both happen; count unchanged; FIFO order preserved.
- Pointer wrap: read/write pointers wrap mod FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- flush_i=1 (synchronous) at the edge:
  - All counts and pointers go to 0.
  - Same-cycle pushes and grants are discarded; wb_valid_o is forced to 0 in the flush cycle.
  - rr_ptr <= 0; overflow_o unchanged.
- Flush has priority over push and pop. Reset has priority over everything.
- Per-unit ordering: results from one unit leave in push order. No ordering is guaranteed across units.

Test Plan:
- Single result: reset, unit 3 pushes result=0xDEADBEEF, rob=5, preg=17, one cycle → next cycle wb_valid_o=2'b01, port0 carries those values, wb_unit_id=3; following cycle wb_valid_o=0.
- Port sharing: units 0,1,2 push together (NUM_WB_PORTS=2) → cycle1 ports show units 0,1; cycle2 port0 shows unit 2; rr_ptr=3 afterwards.
- Fairness: units 0 and 6 push every cycle with NUM_WB_PORTS=1 → grants alternate 0,6,0,6; neither starves.
- Full/overflow: unit 4 pushes 3 consecutive cycles while the arbiter is blocked (units 0-3 continuously pushing, NUM_WB_PORTS=1, DEPTH=2) → unit_ready_o[4]=0 after 2 pushes; third push sets overflow_o=1; exactly 2 entries later drain in order.
- Flush: fill units 1 and 5 with 2 entries each, assert flush_i with a new unit 2 push → next cycle wb_valid_o=0, unit_ready_o all ones, no stale entries ever emerge.
- Async reset mid-stream: drop rst_n between edges while FIFOs are non-empty → outputs go to 0 immediately; after release, no prior entries appear.
